// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS sequencer: opcodes, FSM states,
// datapath select encodings and the control-vector struct.
package mips_defs;

   // Primary opcodes (instruction[31:26]) the sequencer understands
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // Sequencer states; encodings 12..15 are unused and recover to FETCH
   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_MEM_ADDR  = 4'd2,
      ST_MEM_READ  = 4'd3,
      ST_MEM_WB    = 4'd4,
      ST_MEM_WRITE = 4'd5,
      ST_R_EXEC    = 4'd6,
      ST_R_WB      = 4'd7,
      ST_BRANCH    = 4'd8,
      ST_JUMP      = 4'd9,
      ST_I_EXEC    = 4'd10,
      ST_I_WB      = 4'd11
   } state_t;

   // ALU operation select
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   // ALU B operand select
   typedef enum logic [1:0] {
      SRCB_RT     = 2'b00,
      SRCB_FOUR   = 2'b01,
      SRCB_IMM    = 2'b10,
      SRCB_IMM_SH = 2'b11
   } alusrcb_t;

   // Next-PC source select
   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pcsrc_t;

   // Full datapath control vector produced by the decoder
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      alusrcb_t   alu_src_b;
      aluop_t     alu_op;
      pcsrc_t     pc_source;
   } ctrl_t;

   // True for opcodes that DECODE can dispatch
   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state -> control-vector decoder. Only the FETCH
// IRWrite/PCWrite pair looks at mem_ready; everything else is pure state.
module control_decode
   import mips_defs::*;
(
   input  state_t i_state,
   input  logic   i_mem_ready,
   output ctrl_t  o_ctrl
);

   // Per-state control assertions; anything not named stays 0
   always_comb begin
      o_ctrl = '0;
      case (i_state)
         ST_FETCH: begin
            o_ctrl.mem_read  = 1'b1;
            o_ctrl.alu_src_b = SRCB_FOUR;
            o_ctrl.ir_write  = i_mem_ready;
            o_ctrl.pc_write  = i_mem_ready;
         end
         ST_DECODE: begin
            o_ctrl.alu_src_b = SRCB_IMM_SH;
         end
         ST_MEM_ADDR: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
         end
         ST_MEM_READ: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.i_or_d   = 1'b1;
         end
         ST_MEM_WB: begin
            o_ctrl.mem_to_reg = 1'b1;
            o_ctrl.reg_write  = 1'b1;
         end
         ST_MEM_WRITE: begin
            o_ctrl.mem_write = 1'b1;
            o_ctrl.i_or_d    = 1'b1;
         end
         ST_R_EXEC: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_RT;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         ST_R_WB: begin
            o_ctrl.reg_dst   = 1'b1;
            o_ctrl.reg_write = 1'b1;
         end
         ST_BRANCH: begin
            o_ctrl.alu_src_a     = 1'b1;
            o_ctrl.alu_src_b     = SRCB_RT;
            o_ctrl.alu_op        = ALUOP_SUB;
            o_ctrl.pc_write_cond = 1'b1;
            o_ctrl.pc_source     = PCSRC_ALUOUT;
         end
         ST_JUMP: begin
            o_ctrl.pc_write  = 1'b1;
            o_ctrl.pc_source = PCSRC_JUMP;
         end
         ST_I_EXEC: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
         end
         ST_I_WB: begin
            o_ctrl.reg_write = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: state register, next-state dispatch, memory
// handshake stalls and a retired-instruction counter.
module multicycle_control
   import mips_defs::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             memRead,
   output logic             memWrite,
   output logic             IRWrite,
   output logic             memToReg,
   output logic             regDst,
   output logic             regWrite,
   output logic             aluSrcA,
   output logic [1:0]       aluSrcB,
   output logic [1:0]       aluOp,
   output logic [1:0]       PCSource,
   output logic             illegal_op,
   output logic [CNT_W-1:0] retired
);

   state_t           r_state;
   state_t           w_next_state;
   state_t           w_dec_state;
   logic             w_retire;
   ctrl_t            w_ctrl;
   logic [CNT_W-1:0] r_retired;

   // Holding reset presents the FETCH decode regardless of the stored state
   assign w_dec_state = rst ? ST_FETCH : r_state;

   control_decode u_decode (
      .i_state     (w_dec_state),
      .i_mem_ready (mem_ready),
      .o_ctrl      (w_ctrl)
   );

   // Next-state dispatch; memory states stall until mem_ready
   always_comb begin
      w_next_state = ST_FETCH;
      case (r_state)
         ST_FETCH:     w_next_state = mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            case (opcode)
               OP_RTYPE:     w_next_state = ST_R_EXEC;
               OP_LW, OP_SW: w_next_state = ST_MEM_ADDR;
               OP_BEQ:       w_next_state = ST_BRANCH;
               OP_J:         w_next_state = ST_JUMP;
               OP_ADDI:      w_next_state = ST_I_EXEC;
               default:      w_next_state = ST_FETCH;
            endcase
         end
         ST_MEM_ADDR: begin
            if (opcode == OP_LW)      w_next_state = ST_MEM_READ;
            else if (opcode == OP_SW) w_next_state = ST_MEM_WRITE;
            else                      w_next_state = ST_FETCH;
         end
         ST_MEM_READ:  w_next_state = mem_ready ? ST_MEM_WB : ST_MEM_READ;
         ST_MEM_WB:    w_next_state = ST_FETCH;
         ST_MEM_WRITE: w_next_state = mem_ready ? ST_FETCH : ST_MEM_WRITE;
         ST_R_EXEC:    w_next_state = ST_R_WB;
         ST_R_WB:      w_next_state = ST_FETCH;
         ST_BRANCH:    w_next_state = ST_FETCH;
         ST_JUMP:      w_next_state = ST_FETCH;
         ST_I_EXEC:    w_next_state = ST_I_WB;
         ST_I_WB:      w_next_state = ST_FETCH;
         default:      w_next_state = ST_FETCH;
      endcase
   end

   // An instruction retires on the cycle its final state hands back to FETCH
   always_comb begin
      w_retire = 1'b0;
      case (r_state)
         ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_I_WB: w_retire = 1'b1;
         ST_MEM_WRITE:                                    w_retire = mem_ready;
         default:                                         w_retire = 1'b0;
      endcase
   end

   // State and retired counter; reset wins over any pending transition
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_FETCH;
         r_retired <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_retire) r_retired <= r_retired + CNT_W'(1);
      end
   end

   assign PCWrite     = w_ctrl.pc_write;
   assign PCWriteCond = w_ctrl.pc_write_cond;
   assign IorD        = w_ctrl.i_or_d;
   assign memRead     = w_ctrl.mem_read;
   assign memWrite    = w_ctrl.mem_write;
   assign IRWrite     = w_ctrl.ir_write;
   assign memToReg    = w_ctrl.mem_to_reg;
   assign regDst      = w_ctrl.reg_dst;
   assign regWrite    = w_ctrl.reg_write;
   assign aluSrcA     = w_ctrl.alu_src_a;
   assign aluSrcB     = w_ctrl.alu_src_b;
   assign aluOp       = w_ctrl.alu_op;
   assign PCSource    = w_ctrl.pc_source;
   assign illegal_op  = !rst && (r_state == ST_DECODE) && !is_legal_op(opcode);
   assign retired     = r_retired;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle sequencer for the MIPS core: drives register file, ALU, PC and unified memory controls through per-instruction state sequences.
- Replaces the single-cycle unit_control decode in the ID stage.
- Sits between the instruction register (opcode field) and the datapath muxes/enables.
- Stalls on a memory-ready handshake and keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- opcode  input  6  instruction[31:26] from the instruction register.
- mem_ready  input  1  memory completes the current read/write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by ALU zero (beq).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead  output  1  memory read request.
- memWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- memToReg  output  1  write-back select: 1 = MDR, 0 = ALUOut.
- regDst  output  1  destination select: 1 = rd, 0 = rt.
- regWrite  output  1  register file write enable.
- aluSrcA  output  1  ALU A select: 0 = PC, 1 = rs.
- aluSrcB  output  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- aluOp  output  2  00 = add, 01 = sub, 10 = funct-decoded.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  output  1  one-cycle pulse when an unknown opcode is decoded.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset: on a clk edge with rst=1, state<=FETCH, retired<=0.
- Synchronous reset overrides any transition, including mid-wait in a memory state; there is no partial completion and no retired increment.
- Output timing: all outputs are decoded from state. Only FETCH IRWrite/PCWrite depend on mem_ready.
- Every control not listed for a state is 0.
- With rst held, outputs equal the FETCH decode.
- States and asserted controls:
- FETCH: memRead=1, IorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, PCSource=00, IRWrite=mem_ready, PCWrite=mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Dispatch on opcode:
  - 000000 -> R_EXEC
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> I_EXEC
  - any other opcode -> FETCH, with illegal_op=1 this cycle; retired not incremented.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=00. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: memRead=1, IorD=1. Stay until mem_ready, then go to MEM_WB.
- MEM_WB: regDst=0, memToReg=1, regWrite=1. Go to FETCH.
- MEM_WRITE: memWrite=1, IorD=1. Stay until mem_ready, then go to FETCH.
- R_EXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Go to R_WB.
- R_WB: regDst=1, memToReg=0, regWrite=1. Go to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, PCWriteCond=1, PCSource=01. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- I_EXEC: aluSrcA=1, aluSrcB=10, aluOp=00. Go to I_WB.
- I_WB: regDst=0, memToReg=0, regWrite=1. Go to FETCH.
- Latency with zero-wait memory: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.
- Each memory wait cycle adds one cycle.
- Request stability: memRead/memWrite and the address select stay constant while waiting. Each access is exactly one request held until mem_ready.
- Retired counter: increments by 1 on the cycle the FSM leaves MEM_WB, MEM_WRITE (with mem_ready), R_WB, BRANCH, JUMP or I_WB for FETCH. It wraps modulo 2^CNT_W.
- Opcode sampling: opcode is sampled only in DECODE and MEM_ADDR. It is don't-care in all other states.
- Unused state encodings go to FETCH on the next edge.

Decomposition:
- Shared package mips_defs: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), state enum (4-bit), aluOp / aluSrcB / PCSource encodings.
- Natural split: sub-module control_decode, a purely combinational state(+mem_ready) -> control-vector decoder.
- The top level holds the state register, next-state logic and retired counter.

Test Plan:
- rst=1 for 2 cycles, mem_ready=1 -> memRead=1, IorD=0, retired=0. First cycle after release: IRWrite=1, PCWrite=1.
- R-type (opcode 000000), mem_ready=1 -> FETCH, DECODE, R_EXEC, R_WB. regWrite=1 with regDst=1 only in cycle 4; retired 0->1.
- lw with mem_ready low for 3 cycles in MEM_READ -> memRead=1, IorD=1 held for 4 cycles. Total 8 cycles; MEM_WB asserts memToReg=1, regWrite=1.
- sw, then beq, then j -> sw: memWrite for exactly one cycle with zero wait, regWrite never set. beq: PCWriteCond=1, aluOp=01. j: PCWrite=1, PCSource=10. retired advances by 3 after 10 cycles.
- opcode 111111 -> illegal_op pulses 1 cycle in DECODE, FETCH follows, retired unchanged.
- rst asserted during a MEM_WRITE wait -> next cycle is FETCH, memWrite=0, retired=0.
